// File: rtl/serial_alu_seq_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
// The zero port exists only when ZERO_FLAG_EN is defined.
interface serial_alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [1:0]       sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output start, sel, op_a, op_b, cin,
        input  busy, done, result, cout
`ifdef ZERO_FLAG_EN
        , input zero
`endif
    );

    modport slave (
        input  start, sel, op_a, op_b, cin,
        output busy, done, result, cout
`ifdef ZERO_FLAG_EN
        , output zero
`endif
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer around a 1-bit arithmetic slice, LSB first over WIDTH cycles.
// Optional zero flag when ZERO_FLAG_EN is defined.
module serial_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_alu_seq_if.slave  bus,
    output logic             slice_s1,
    output logic             slice_s0,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_f,
    input  logic             slice_cout
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic             bit_s;
    logic             carry_s;

    // Transfer mode bypasses the slice, whose 00 path is not carry-safe.
    function automatic logic [1:0] pick_bit(input logic [1:0] s, input logic a0,
                                            input logic f, input logic co);
        logic [1:0] r;
        if (s == 2'b00) begin
            r = {1'b0, a0};
        end else begin
            r = {co, f};
        end
        return r;
    endfunction

    assign {carry_s, bit_s} = pick_bit(sel_q, a_sh_q[0], slice_f, slice_cout);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    sel_d   = bus.sel;
                    a_sh_d  = bus.op_a;
                    b_sh_d  = bus.op_b;
                    carry_d = bus.cin;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_sh_d = {bit_s, res_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = carry_s;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = CNT_ZERO;
                    result_d = res_sh_d;
                    cout_d   = carry_s;
                    done_d   = 1'b1;
`ifdef ZERO_FLAG_EN
                    zero_d   = (res_sh_d == {WIDTH{1'b0}});
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 2'b00;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= CNT_ZERO;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            sel_q    <= sel_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
`ifdef ZERO_FLAG_EN
    assign bus.zero   = zero_q;
`endif

    assign slice_s1  = sel_q[1];
    assign slice_s0  = sel_q[0];
    assign slice_a   = a_sh_q[0];
    assign slice_b   = b_sh_q[0];
    assign slice_cin = carry_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed, table-driven bench for serial_alu_seq (WIDTH=4) with a behavioural 1-bit slice.
module tb_serial_alu_seq;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic slice_s1, slice_s0, slice_a, slice_b, slice_cin;
    logic slice_f, slice_cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .slice_s1   (slice_s1),
        .slice_s0   (slice_s0),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_f    (slice_f),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    // 1-bit slice model; the 00 path returns junk so the bypass is exercised.
    always_comb begin
        logic [1:0] sum;
        sum = 2'b00;
        case ({slice_s1, slice_s0})
            2'b01:   sum = {1'b0, slice_a}  + {1'b0, slice_b}  + {1'b0, slice_cin};
            2'b10:   sum = {1'b0, slice_a}  + {1'b0, ~slice_b} + {1'b0, slice_cin};
            2'b11:   sum = {1'b0, ~slice_a} + {1'b0, slice_b}  + {1'b0, slice_cin};
            default: sum = {1'b1, ~slice_a};
        endcase
        {slice_cout, slice_f} = sum;
    end

    typedef struct {
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] res;
        logic       co;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                          input logic c);
        bus.start = 1'b1;
        bus.sel   = s;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called in the first RUN cycle; returns in the done cycle.
    task automatic expect_run(input string nm, input logic [3:0] er, input logic ec,
                              input bit inject);
        for (int i = 0; i < WIDTH; i++) begin
            check({nm, " busy"}, {31'd0, bus.busy}, 32'd1);
            check({nm, " done_in_run"}, {31'd0, bus.done}, 32'd0);
            if (inject && i == 1) begin
                bus.start = 1'b1;
                bus.sel   = 2'b01;
                bus.op_a  = 4'h5;
                bus.op_b  = 4'h6;
                bus.cin   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({nm, " done"}, {31'd0, bus.done}, 32'd1);
        check({nm, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({nm, " result"}, {28'd0, bus.result}, {28'd0, er});
        check({nm, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef ZERO_FLAG_EN
        check({nm, " zero"}, {31'd0, bus.zero}, {31'd0, (er == 4'h0)});
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.sel   = 2'b00;
        bus.op_a  = 4'h0;
        bus.op_b  = 4'h0;
        bus.cin   = 1'b0;

        vecs[0] = '{sel: 2'b01, a: 4'h5, b: 4'h3, cin: 1'b0, res: 4'h8, co: 1'b0};
        vecs[1] = '{sel: 2'b01, a: 4'hF, b: 4'h1, cin: 1'b0, res: 4'h0, co: 1'b1};
        vecs[2] = '{sel: 2'b10, a: 4'h9, b: 4'h4, cin: 1'b1, res: 4'h5, co: 1'b1};
        vecs[3] = '{sel: 2'b11, a: 4'h2, b: 4'h7, cin: 1'b1, res: 4'h5, co: 1'b1};
        vecs[4] = '{sel: 2'b00, a: 4'hA, b: 4'hF, cin: 1'b1, res: 4'hA, co: 1'b0};
        vecs[5] = '{sel: 2'b01, a: 4'h0, b: 4'h0, cin: 1'b1, res: 4'h1, co: 1'b0};
        vecs[6] = '{sel: 2'b10, a: 4'h5, b: 4'h5, cin: 1'b1, res: 4'h0, co: 1'b1};
        vecs[7] = '{sel: 2'b11, a: 4'hF, b: 4'hF, cin: 1'b0, res: 4'hF, co: 1'b0};
        vecs[8] = '{sel: 2'b10, a: 4'h3, b: 4'h5, cin: 1'b0, res: 4'hD, co: 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst result", {28'd0, bus.result}, 32'd0);
        check("rst cout", {31'd0, bus.cout}, 32'd0);
        check("rst slice_s1", {31'd0, slice_s1}, 32'd0);
        check("rst slice_s0", {31'd0, slice_s0}, 32'd0);
        check("rst slice_a", {31'd0, slice_a}, 32'd0);
        check("rst slice_b", {31'd0, slice_b}, 32'd0);
        check("rst slice_cin", {31'd0, slice_cin}, 32'd0);
`ifdef ZERO_FLAG_EN
        check("rst zero", {31'd0, bus.zero}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Table of single operations
        for (int v = 0; v < 9; v++) begin
            launch(vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].cin);
            expect_run($sformatf("vec%0d", v), vecs[v].res, vecs[v].co, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", v), {31'd0, bus.done}, 32'd0);
            check($sformatf("vec%0d idle", v), {31'd0, bus.busy}, 32'd0);
            check($sformatf("vec%0d hold", v), {28'd0, bus.result}, {28'd0, vecs[v].res});
        end

        // Start during RUN is ignored
        launch(2'b00, 4'hA, 4'hF, 1'b1);
        expect_run("ignore_start", 4'hA, 1'b0, 1'b1);
        @(negedge clk);
        check("ignore_start no_rerun", {31'd0, bus.busy}, 32'd0);
        check("ignore_start done_pulse", {31'd0, bus.done}, 32'd0);

        // Back-to-back: start held in the DONE cycle
        @(negedge clk);
        launch(2'b01, 4'h1, 4'h2, 1'b0);
        expect_run("b2b_first", 4'h3, 1'b0, 1'b0);
        launch(2'b01, 4'h3, 4'h3, 1'b0);
        expect_run("b2b_second", 4'h6, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in RUN at count 2
        launch(2'b01, 4'hC, 4'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst result", {28'd0, bus.result}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst slice_a", {31'd0, slice_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no_done", {31'd0, bus.done}, 32'd0);
            check("midrst no_busy", {31'd0, bus.busy}, 32'd0);
        end
        launch(2'b01, 4'h7, 4'h1, 1'b0);
        expect_run("after_rst", 4'h8, 1'b0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial sequencer that drives one 1-bit arithmetic slice (s1, s0, a, b, cin in; f, cout out) over WIDTH clock cycles, LSB first.
- Latches a WIDTH-bit operation on start, feeds one operand bit pair per cycle, and registers the slice carry-out back as the next cin.
- Collects the sum bits into a result register.
- Sits directly around the arithmetic slice: upstream as its operand/carry feeder, downstream as the consumer of f/cout.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sel  input  2  {s1,s0} operation select; latched on accepted start.
- op_a  input  WIDTH  operand A; latched on accepted start.
- op_b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  initial carry; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result/cout are updated.
- result  output  WIDTH  final result; held until next done.
- cout  output  1  final carry; held until next done.
- slice_s1, slice_s0  output  1 each  drive slice select = latched sel.
- slice_a, slice_b, slice_cin  output  1 each  current operand bits and running carry to the slice.
- slice_f, slice_cout  input  1 each  slice sum and carry-out.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, cout = 0; result = 0; all internal shift/carry/count registers = 0; slice_* outputs = 0.
- States:
  - IDLE: start=1 -> RUN. Latch op_a/op_b into shift registers, sel, carry<=cin, count<=0.
  - RUN: each cycle, capture slice_f into the MSB of the result shift register (shift right), carry<=slice_cout, shift operands right, count++.
    - At count==WIDTH-1, go to DONE; result<=assembled word; cout<=final carry.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back ops) and goes to RUN.
    - Otherwise go to IDLE.
- Slice drive: slice_a = A_sh[0], slice_b = B_sh[0], slice_cin = carry, {slice_s1,slice_s0} = latched sel. All are registered-sourced (no combinational path from start/op_*). Values are don't-care outside RUN but must be 0 after reset.
- sel=00 (transfer): the slice's 00 path is not carry-safe. In this mode the sequencer ignores slice_f/slice_cout: each result bit = A_sh[0], carry forced 0, final cout=0.
- Latency: start sampled at edge T -> busy high T+1..T+WIDTH -> done high during cycle T+WIDTH+1; result/cout valid from that cycle on.
- start while busy: ignored; op_*/sel changes during RUN have no effect.
- busy and done are never high together.
- Arithmetic: the result is modulo 2^WIDTH; cout is the carry out of bit WIDTH-1. Subtract/negate semantics are those of the slice (01: A+B+cin; 10: A+~B+cin; 11: ~A+B+cin).
- Reset mid-RUN: abort immediately, no done pulse, result cleared to 0.

Optional Feature:
- ZERO_FLAG_EN: adds output port zero (1 bit), registered together with result at done: zero = (final result == 0).
  - Reset value 0; held until next done.
  - Without the macro the port and its logic do not exist.

Test Plan:
- After rst pulse: busy=0, done=0, result=0, cout=0, slice_*=0.
- WIDTH=4, sel=01, op_a=5, op_b=3, cin=0, start at T: busy high T+1..T+4, done pulse at T+5, result=8, cout=0. Then sel=01, A=F, B=1, cin=0 -> result=0, cout=1 (zero=1 with ZERO_FLAG_EN).
- sel=10, A=9, B=4, cin=1 -> result=5, cout=1; sel=11, A=2, B=7, cin=1 -> result=5, cout=1.
- sel=00, A=A, B=F, cin=1 -> result=A, cout=0. A start pulse with different operands during RUN -> ignored, result still A.
- Start held high in the DONE cycle with A=3, B=3, sel=01 -> new RUN begins immediately, next done 5 cycles later with result=6.
- rst asserted at RUN count 2 -> immediately busy=0, result=0, no done. Next op A=7, B=1, sel=01, cin=0 -> result=8, cout=0.
